// File: rtl/reply_seq_pkg.sv
// Shared types and pattern-step helper for the reply_seq test-pattern responder.
package reply_seq_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam logic [7:0] LFSR_POLY = 8'hB8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_LOAD,
    ST_TXREQ,
    ST_TXWAIT,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    MODE_INC   = 2'd0,
    MODE_DEC   = 2'd1,
    MODE_CONST = 2'd2,
    MODE_LFSR  = 2'd3
  } mode_t;

  // Next pattern value for a given mode; LFSR is Galois, right-shifting.
  function automatic logic [7:0] gen_next(input mode_t mode, input logic [7:0] v);
    logic [7:0] r;
    case (mode)
      MODE_INC:   r = v + 8'd1;
      MODE_DEC:   r = v - 8'd1;
      MODE_CONST: r = v;
      MODE_LFSR:  r = v[0] ? ((v >> 1) ^ LFSR_POLY) : (v >> 1);
      default:    r = v;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/reply_seq_gen.sv
// Pattern register for reply_seq: load(seed, mode) primes the value, step advances it.
module reply_seq_gen
  import reply_seq_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        step,
  input  logic [7:0]  seed,
  input  mode_t       mode,
  output logic [7:0]  value
);

  mode_t mode_q;

  // An all-zero LFSR would lock up, so a zero seed is replaced in that mode.
  always_ff @(posedge clk) begin
    if (reset) begin
      value  <= '0;
      mode_q <= MODE_INC;
    end else if (load) begin
      mode_q <= mode;
      value  <= (mode == MODE_LFSR && seed == 8'h00) ? 8'h01 : seed;
    end else if (step) begin
      value  <= gen_next(mode_q, value);
    end
  end

endmodule

// File: rtl/reply_seq.sv
// UART test-pattern responder: takes a MODE/LEN/SEED header from RX, streams LEN bytes to TX.
// Optional header inter-byte timeout is enabled by defining REPLY_SEQ_TIMEOUT_EN.
module reply_seq
  import reply_seq_pkg::*;
#(
  parameter int unsigned LEN_BYTES   = 2,
  parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        activate,
  output logic        done,
  output logic        err,
  output logic        busy,
  input  logic        rx_ready,
  input  logic [7:0]  rx_data,
  input  logic        tx_active,
  input  logic        tx_done,
  output logic [7:0]  tx_data,
  output logic        tx_start
);

  localparam int unsigned LEN_W = BYTE_W * LEN_BYTES;
  localparam int unsigned IDX_W = $clog2(LEN_BYTES + 2);

  if (LEN_BYTES < 1 || TIMEOUT_CYC < 2) begin : g_param_check
    $error("reply_seq: LEN_BYTES must be >= 1 and TIMEOUT_CYC >= 2");
  end

  state_t           state_q, state_d;
  logic             rx_ready_q;
  logic             rx_ev;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       mode_q, mode_d;
  logic [7:0]       seed_q, seed_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             err_d, done_d, busy_d, tx_start_d;
  logic [7:0]       tx_data_d;
  logic             gen_load, gen_step;
  logic [7:0]       gen_value;

`ifdef REPLY_SEQ_TIMEOUT_EN
  localparam int unsigned TO_W = ($clog2(TIMEOUT_CYC + 1) > 20) ? $clog2(TIMEOUT_CYC + 1) : 20;
  logic [TO_W-1:0] to_q, to_d;
`endif

  assign rx_ev = rx_ready & ~rx_ready_q;

  reply_seq_gen u_gen (
    .clk   (clk),
    .reset (reset),
    .load  (gen_load),
    .step  (gen_step),
    .seed  (seed_q),
    .mode  (mode_t'(mode_q[1:0])),
    .value (gen_value)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      rx_ready_q <= 1'b0;
      idx_q      <= '0;
      mode_q     <= '0;
      seed_q     <= '0;
      len_q      <= '0;
      rem_q      <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      busy       <= 1'b0;
      tx_start   <= 1'b0;
      tx_data    <= '0;
`ifdef REPLY_SEQ_TIMEOUT_EN
      to_q       <= '0;
`endif
    end else begin
      state_q    <= state_d;
      rx_ready_q <= rx_ready;
      idx_q      <= idx_d;
      mode_q     <= mode_d;
      seed_q     <= seed_d;
      len_q      <= len_d;
      rem_q      <= rem_d;
      done       <= done_d;
      err        <= err_d;
      busy       <= busy_d;
      tx_start   <= tx_start_d;
      tx_data    <= tx_data_d;
`ifdef REPLY_SEQ_TIMEOUT_EN
      to_q       <= to_d;
`endif
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    mode_d     = mode_q;
    seed_d     = seed_q;
    len_d      = len_q;
    rem_d      = rem_q;
    err_d      = err;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data;
    gen_load   = 1'b0;
    gen_step   = 1'b0;
`ifdef REPLY_SEQ_TIMEOUT_EN
    to_d       = to_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (activate) begin
          state_d = ST_HDR;
          idx_d   = '0;
          len_d   = '0;
          err_d   = 1'b0;
`ifdef REPLY_SEQ_TIMEOUT_EN
          to_d    = '0;
`endif
        end
      end

      ST_HDR: begin
        if (!activate) begin
          state_d = ST_IDLE;
        end else if (rx_ev) begin
          idx_d = idx_q + 1'b1;
`ifdef REPLY_SEQ_TIMEOUT_EN
          to_d  = '0;
`endif
          if (idx_q == '0) begin
            mode_d = rx_data;
          end else if (idx_q <= IDX_W'(LEN_BYTES)) begin
            // Length arrives MSB first: shift left by a byte.
            len_d = LEN_W'({len_q, rx_data});
          end else begin
            seed_d  = rx_data;
            state_d = ST_LOAD;
          end
        end
`ifdef REPLY_SEQ_TIMEOUT_EN
        else if (to_q >= TO_W'(TIMEOUT_CYC - 1)) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
        end else begin
          to_d = to_q + 1'b1;
        end
`endif
      end

      ST_LOAD: begin
        if (mode_q > 8'd3) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
        end else if (len_q == '0) begin
          state_d = ST_DONE;
        end else begin
          gen_load = 1'b1;
          rem_d    = len_q;
          state_d  = ST_TXREQ;
        end
      end

      ST_TXREQ: begin
        if (!activate) begin
          state_d = ST_DONE;
        end else if (!tx_active) begin
          tx_start_d = 1'b1;
          tx_data_d  = gen_value;
          state_d    = ST_TXWAIT;
        end
      end

      ST_TXWAIT: begin
        // The in-flight byte always completes; activate is only honoured here.
        if (tx_done) begin
          gen_step = 1'b1;
          rem_d    = (rem_q != '0) ? rem_q - 1'b1 : rem_q;
          if (rem_q <= LEN_W'(1) || !activate) state_d = ST_DONE;
          else                                 state_d = ST_TXREQ;
        end
      end

      ST_DONE: begin
        if (!activate && !rx_ready && !tx_active) begin
          state_d = ST_IDLE;
          err_d   = 1'b0;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    done_d = (state_d == ST_DONE);
    busy_d = (state_d != ST_IDLE);
  end

endmodule

// File: tb/tb_reply_seq.sv
// Directed self-checking bench for reply_seq with a behavioural uart_tx stand-in.
module tb_reply_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       activate;
  logic       done, err, busy;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       tx_active;
  logic       tx_done;
  logic [7:0] tx_data;
  logic       tx_start;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] cap[$];
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  reply_seq #(.LEN_BYTES(2), .TIMEOUT_CYC(100)) dut (
    .clk       (clk),
    .reset     (reset),
    .activate  (activate),
    .done      (done),
    .err       (err),
    .busy      (busy),
    .rx_ready  (rx_ready),
    .rx_data   (rx_data),
    .tx_active (tx_active),
    .tx_done   (tx_done),
    .tx_data   (tx_data),
    .tx_start  (tx_start)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // uart_tx stand-in: busy for 3 cycles per byte, then a one-cycle tx_done.
  initial begin
    tx_active = 1'b0;
    tx_done   = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start) begin
        cap.push_back(tx_data);
        tx_active = 1'b1;
        repeat (3) @(negedge clk);
        tx_active = 1'b0;
        tx_done   = 1'b1;
        @(negedge clk);
        tx_done   = 1'b0;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_ready = 1'b1;
    repeat (2) @(negedge clk);
    rx_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_hdr(input logic [7:0] m, input logic [15:0] len, input logic [7:0] s);
    logic [15:0] l;
    l = len;
    send_byte(m);
    send_byte(l[15:8]);
    send_byte(l[7:0]);
    send_byte(s);
  endtask

  task automatic wait_done(input string tag, input int bound);
    int i;
    i = 0;
    while (done !== 1'b1 && i < bound) begin
      @(negedge clk);
      i++;
    end
    check({tag, " done"}, 32'(done), 32'd1);
  endtask

  task automatic check_stream(input string tag);
    check({tag, " count"}, 32'(cap.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < cap.size()) check($sformatf("%s byte%0d", tag, i), 32'(cap[i]), 32'(exp_q[i]));
  endtask

  task automatic release_run(input string tag);
    int i;
    activate = 1'b0;
    i = 0;
    while ((busy !== 1'b0 || tx_active) && i < 50) begin
      @(negedge clk);
      i++;
    end
    check({tag, " idle busy"}, 32'(busy), 32'd0);
    check({tag, " idle done"}, 32'(done), 32'd0);
    check({tag, " idle err"},  32'(err),  32'd0);
  endtask

  task automatic start_run();
    cap.delete();
    @(negedge clk);
    activate = 1'b1;
    @(negedge clk);
  endtask

  task automatic run_case(input string tag, input logic [7:0] m, input logic [15:0] len,
                          input logic [7:0] s, input logic exp_err);
    start_run();
    send_hdr(m, len, s);
    wait_done(tag, 500);
    check({tag, " err"}, 32'(err), 32'(exp_err));
    check_stream(tag);
    release_run(tag);
  endtask

  initial begin
    int i;
    reset    = 1'b1;
    activate = 1'b0;
    rx_ready = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    check("rst done",     32'(done),     32'd0);
    check("rst err",      32'(err),      32'd0);
    check("rst busy",     32'(busy),     32'd0);
    check("rst tx_start", 32'(tx_start), 32'd0);
    check("rst tx_data",  32'(tx_data),  32'd0);
    reset = 1'b0;
    @(negedge clk);

    exp_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
    run_case("inc", 8'h00, 16'd5, 8'h10, 1'b0);

    exp_q = '{8'h01, 8'h00, 8'hFF};
    run_case("dec", 8'h01, 16'd3, 8'h01, 1'b0);

    exp_q = '{8'h01, 8'hB8, 8'h5C, 8'h2E};
    run_case("lfsr", 8'h03, 16'd4, 8'h00, 1'b0);

    exp_q.delete();
    run_case("len0", 8'h02, 16'd0, 8'h7E, 1'b0);

    exp_q.delete();
    run_case("badmode", 8'h07, 16'd2, 8'h00, 1'b1);

    // A byte already pending at activation must not be taken as MODE.
    cap.delete();
    @(negedge clk);
    rx_data  = 8'h07;
    rx_ready = 1'b1;
    repeat (2) @(negedge clk);
    activate = 1'b1;
    repeat (3) @(negedge clk);
    rx_ready = 1'b0;
    @(negedge clk);
    send_hdr(8'h00, 16'd2, 8'h20);
    wait_done("pending", 500);
    check("pending err", 32'(err), 32'd0);
    exp_q = '{8'h20, 8'h21};
    check_stream("pending");
    release_run("pending");

    // Early drop of activate after the third tx_start.
    start_run();
    send_hdr(8'h00, 16'd300, 8'h40);
    i = 0;
    while (cap.size() < 3 && i < 200) begin
      @(negedge clk);
      i++;
    end
    check("abort reached3", 32'(cap.size()), 32'd3);
    activate = 1'b0;
    wait_done("abort", 50);
    check("abort err", 32'(err), 32'd0);
    exp_q = '{8'h40, 8'h41, 8'h42};
    repeat (10) @(negedge clk);
    check_stream("abort");
    release_run("abort");

    // Reset while waiting for tx_done.
    start_run();
    send_hdr(8'h00, 16'd10, 8'h55);
    i = 0;
    while (tx_start !== 1'b1 && i < 100) begin
      @(negedge clk);
      i++;
    end
    check("rstmid started", 32'(tx_start), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rstmid done",     32'(done),     32'd0);
    check("rstmid err",      32'(err),      32'd0);
    check("rstmid busy",     32'(busy),     32'd0);
    check("rstmid tx_start", 32'(tx_start), 32'd0);
    check("rstmid tx_data",  32'(tx_data),  32'd0);
    reset    = 1'b0;
    activate = 1'b0;
    repeat (10) @(negedge clk);

    // Header stalls after MODE.
    start_run();
    send_byte(8'h00);
`ifdef REPLY_SEQ_TIMEOUT_EN
    i = 0;
    while (done !== 1'b1 && i < 300) begin
      @(negedge clk);
      i++;
    end
    check("timeout done", 32'(done), 32'd1);
    check("timeout err",  32'(err),  32'd1);
    check("timeout window", 32'(i >= 90 && i <= 110), 32'd1);
`else
    repeat (10_000) @(negedge clk);
    check("stall busy", 32'(busy), 32'd1);
    check("stall done", 32'(done), 32'd0);
`endif
    release_run("stall");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
